// File: rtl/binary_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter with start/ready/valid handshake.
// The last result and its overflow flag stay stable until the next conversion completes.
module binary_to_bcd_converter #(
    parameter int INPUT_WIDTH = 16,
    parameter int NUM_DIGITS  = 4
) (
    input  logic                      clock,
    input  logic                      resetN,
    input  logic                      start,
    input  logic [INPUT_WIDTH-1:0]    binary,
    output logic                      ready,
    output logic                      valid,
    output logic [4*NUM_DIGITS-1:0]   bcd,
    output logic                      overflow
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(INPUT_WIDTH + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]             state;
    logic [INPUT_WIDTH-1:0] shreg;
    logic [BW-1:0]          acc;
    logic [BW-1:0]          acc_adj;
    logic [BW-1:0]          acc_next;
    logic                   sticky;
    logic                   sticky_next;
    logic [CW-1:0]          count;

    assign ready = (state == IDLE);

    // Add-3 correction is per digit with no inter-digit carry, then one shift step.
    always_comb begin
        acc_adj = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end else begin
                acc_adj[4*i +: 4] = acc[4*i +: 4];
            end
        end
        acc_next    = {acc_adj[BW-2:0], shreg[INPUT_WIDTH-1]};
        sticky_next = sticky | acc_adj[BW-1];
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            shreg    <= '0;
            acc      <= '0;
            sticky   <= 1'b0;
            count    <= '0;
            valid    <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= SHIFT;
                        shreg  <= binary;
                        acc    <= '0;
                        sticky <= 1'b0;
                        count  <= CW'(INPUT_WIDTH);
                    end
                end
                SHIFT: begin
                    acc    <= acc_next;
                    shreg  <= shreg << 1;
                    sticky <= sticky_next;
                    count  <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state    <= IDLE;
                        bcd      <= acc_next;
                        overflow <= sticky_next;
                        valid    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// Directed self-checking bench for binary_to_bcd_converter (16-bit input, 4 digits).
module tb_binary_to_bcd_converter;

    logic        clock;
    logic        resetN;
    logic        start;
    logic [15:0] binary;
    logic        ready;
    logic        valid;
    logic [15:0] bcd;
    logic        overflow;

    int n_checks = 0;
    int n_pass   = 0;

    binary_to_bcd_converter #(
        .INPUT_WIDTH(16),
        .NUM_DIGITS (4)
    ) dut (
        .clock   (clock),
        .resetN  (resetN),
        .start   (start),
        .binary  (binary),
        .ready   (ready),
        .valid   (valid),
        .bcd     (bcd),
        .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Accept one conversion and verify the full 16-edge timeline.
    task automatic convert(input string tag, input logic [15:0] value,
                           input logic [15:0] exp_bcd, input logic exp_ovf);
        int bad;
        bad = 0;
        check({tag, " ready_before"}, 32'(ready), 32'd1);
        binary = value;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start  = 1'b0;
        binary = ~value;
        if (valid || ready) bad++;
        for (int k = 1; k < 16; k++) begin
            @(posedge clock);
            #1;
            if (valid || ready) bad++;
        end
        check({tag, " busy_window"}, 32'(bad), 32'd0);
        @(posedge clock);
        #1;
        check({tag, " valid"}, 32'(valid), 32'd1);
        check({tag, " bcd"}, 32'(bcd), 32'(exp_bcd));
        check({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
        check({tag, " ready_after"}, 32'(ready), 32'd1);
        @(posedge clock);
        #1;
        check({tag, " valid_drop"}, 32'(valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int bad;
        resetN = 1'b0;
        start  = 1'b0;
        binary = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst ready", 32'(ready), 32'd1);
        check("rst valid", 32'(valid), 32'd0);
        check("rst bcd", 32'(bcd), 32'h0);
        check("rst overflow", 32'(overflow), 32'd0);
        @(negedge clock);
        resetN = 1'b1;
        #1;

        convert("zero", 16'd0, 16'h0000, 1'b0);
        convert("1234", 16'd1234, 16'h1234, 1'b0);
        convert("9999", 16'd9999, 16'h9999, 1'b0);
        convert("10000", 16'd10000, 16'h0000, 1'b1);
        convert("65535", 16'd65535, 16'h5535, 1'b1);
        convert("42", 16'd42, 16'h0042, 1'b0);

        // Busy: a start mid-conversion must be ignored and not queued.
        binary = 16'd500;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        cnt = 0;
        bad = 0;
        for (int e = 1; e <= 40; e++) begin
            if (e == 5) begin
                binary = 16'd7;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clock);
            #1;
            if (valid) begin
                cnt++;
                if (e != 16) bad++;
                check("busy bcd", 32'(bcd), 32'h0500);
            end
        end
        start = 1'b0;
        check("busy valid_count", 32'(cnt), 32'd1);
        check("busy valid_timing", 32'(bad), 32'd0);

        bad = 0;
        for (int e = 0; e < 100; e++) begin
            @(posedge clock);
            #1;
            if (bcd !== 16'h0500 || valid) bad++;
        end
        check("hold bcd_stable", 32'(bad), 32'd0);

        // Back-to-back with start held high: results every 17 cycles.
        binary = 16'd1;
        start  = 1'b1;
        @(posedge clock);
        #1;
        binary = 16'd2;
        bad = 0;
        cnt = 0;
        for (int e = 1; e <= 50; e++) begin
            @(posedge clock);
            #1;
            if (e == 17) binary = 16'd3;
            if (e == 50) start = 1'b0;
            if (valid) cnt++;
            if (valid != (e == 16 || e == 33 || e == 50)) bad++;
            if (e == 16) check("b2b bcd1", 32'(bcd), 32'h0001);
            if (e == 33) check("b2b bcd2", 32'(bcd), 32'h0002);
            if (e == 50) check("b2b bcd3", 32'(bcd), 32'h0003);
        end
        check("b2b valid_count", 32'(cnt), 32'd3);
        check("b2b valid_timing", 32'(bad), 32'd0);
        @(posedge clock);
        #1;
        check("b2b no_restart", 32'(ready), 32'd1);

        // Reset in the middle of a conversion discards it.
        binary = 16'd9876;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        resetN = 1'b0;
        #1;
        check("midrst bcd", 32'(bcd), 32'h0);
        check("midrst ready", 32'(ready), 32'd1);
        check("midrst valid", 32'(valid), 32'd0);
        check("midrst overflow", 32'(overflow), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetN = 1'b1;
        cnt = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clock);
            #1;
            if (valid || !ready) cnt++;
        end
        check("midrst no_valid", 32'(cnt), 32'd0);
        convert("9876", 16'd9876, 16'h9876, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
